// File: rtl/csm_initiator.sv
`default_nettype none
// csm_initiator: single-command bus master (hold/address/data/release) for one shared-memory controller port.
// Define CSM_INIT_BACKOFF_EN to retry contention errors with exponential backoff; otherwise errors are reported at once.
module csm_initiator #(
    parameter int DATABITS     = 8,
    parameter int MEMSIZE      = 8,
    parameter int MAX_RETRY    = 3,
    parameter int BACKOFF_BASE = 2,
    parameter int PORT_ID      = 0,
    localparam int MEMBITS     = $clog2(MEMSIZE)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [MEMBITS-1:0]  cmd_addr,
    input  logic [DATABITS-1:0] cmd_wdata,
    output logic                rsp_valid,
    output logic [DATABITS-1:0] rsp_rdata,
    output logic [1:0]          rsp_err,
    output logic [DATABITS-1:0] bus_ad,
    output logic                bus_rw,
    output logic                bus_enable,
    output logic                bus_hold,
    output logic                bus_release,
    input  logic [DATABITS-1:0] bus_rdata,
    input  logic [1:0]          bus_err,
    input  logic                bus_ack
);

`ifdef CSM_INIT_BACKOFF_EN
    typedef enum logic [2:0] {IDLE, HOLD, ADDR, DATA, RELEASE, BACKOFF} state_t;
    localparam state_t FAIL_STATE = BACKOFF;
`else
    typedef enum logic [2:0] {IDLE, HOLD, ADDR, DATA, RELEASE, ERR_RSP} state_t;
    localparam state_t FAIL_STATE = ERR_RSP;
`endif

    state_t                state;
    state_t                state_nxt;
    logic                  write_q;
    logic [MEMBITS-1:0]    addr_q;
    logic [DATABITS-1:0]   wdata_q;
    logic [1:0]            err_q;
    logic                  attempt_fail;
    logic                  give_up;

    // Marker scope that shows up in the hierarchy when a retry parameter is out of range.
    if (MAX_RETRY < 0 || MAX_RETRY > 15 || BACKOFF_BASE < 1 || PORT_ID < 0 || PORT_ID > 1) begin : g_param_range_violation
    end

    assign attempt_fail = (state == HOLD && !(bus_ack && bus_err == 2'd0)) ||
                          (state == ADDR && bus_err != 2'd0);

`ifdef CSM_INIT_BACKOFF_EN
    logic [3:0]  retry_cnt;
    logic [7:0]  boff_cnt;
    logic [31:0] boff_shift;
    logic [7:0]  boff_load;
    logic        retry_last;

    assign retry_last = (retry_cnt == 4'(MAX_RETRY));
    assign give_up    = (state == BACKOFF) && retry_last;
    assign boff_shift = 32'(BACKOFF_BASE) << retry_cnt;
    // Counter holds (length - 1) so BACKOFF occupies exactly the backoff length in cycles.
    assign boff_load  = 8'(((boff_shift > 32'd255) ? 32'd255 : boff_shift) + 32'(PORT_ID) - 32'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retry_cnt <= '0;
            boff_cnt  <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                retry_cnt <= '0;
            end else if (state == BACKOFF && !retry_last && boff_cnt == 8'd0) begin
                retry_cnt <= retry_cnt + 4'd1;
            end
            if (attempt_fail) begin
                boff_cnt <= boff_load;
            end else if (state == BACKOFF && boff_cnt != 8'd0) begin
                boff_cnt <= boff_cnt - 8'd1;
            end
        end
    end
`else
    assign give_up = (state == ERR_RSP);
`endif

    always_comb begin
        state_nxt   = state;
        cmd_ready   = 1'b0;
        bus_ad      = '0;
        bus_rw      = 1'b0;
        bus_enable  = 1'b0;
        bus_hold    = 1'b0;
        bus_release = 1'b0;
        rsp_valid   = give_up;
        rsp_err     = give_up ? err_q : 2'd0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = HOLD;
            end
            HOLD: begin
                bus_hold  = 1'b1;
                state_nxt = attempt_fail ? FAIL_STATE : ADDR;
            end
            ADDR: begin
                bus_hold   = 1'b1;
                bus_enable = 1'b1;
                bus_rw     = write_q;
                bus_ad     = DATABITS'(addr_q);
                state_nxt  = attempt_fail ? FAIL_STATE : DATA;
            end
            DATA: begin
                bus_hold  = 1'b1;
                if (write_q) bus_ad = wdata_q;
                state_nxt = RELEASE;
            end
            RELEASE: begin
                bus_release = 1'b1;
                rsp_valid   = 1'b1;
                state_nxt   = IDLE;
            end
`ifdef CSM_INIT_BACKOFF_EN
            BACKOFF: begin
                if (retry_last)          state_nxt = IDLE;
                else if (boff_cnt == 8'd0) state_nxt = HOLD;
            end
`else
            ERR_RSP: state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 2'd0;
            rsp_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && cmd_valid) begin
                write_q <= cmd_write;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
            end
            if (attempt_fail) err_q <= bus_err;
            if (state == DATA && !write_q) rsp_rdata <= bus_rdata;
        end
    end

endmodule
`default_nettype wire

// File: doc/csm_initiator.md
# csm_initiator

Processor-side bus master for the two-port shared memory controller. It accepts single read/write commands from a local valid/ready interface and runs the hold → address → data → release sequence on one controller port. It resolves contention errors (IN_USE, DUAL_HOLD, DUAL_WRITE) by bounded retry with backoff and returns read data or a final status. One instance sits in front of each processor port (A and B).

## Interface
- DATABITS, 8, width of the multiplexed address/data bus and data words
- MEMSIZE, 8, controller register count; MEMBITS = $clog2(MEMSIZE)
- MAX_RETRY, 3, retries after the first attempt before giving up (0..15)
- BACKOFF_BASE, 2, base backoff length in cycles (≥1)
- PORT_ID, 0, 0 for port A, 1 for port B; added to backoff to break symmetry
- Reset: reset_n, asynchronous, active-low. Clock: clk.
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  local command request
- cmd_ready  output  1  high only in IDLE
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  MEMBITS  register address
- cmd_wdata  input  DATABITS  write data
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  DATABITS  read data; holds its last value
- rsp_err  output  2  0 OK, else last bus error code when retries are exhausted
- bus_ad  output  DATABITS  address in ADDR, write data in DATA, 0 otherwise
- bus_rw  output  1  write flag, driven in ADDR only
- bus_enable  output  1  high in ADDR only
- bus_hold  output  1  high in HOLD, ADDR, DATA
- bus_release  output  1  high in RELEASE only
- bus_rdata  input  DATABITS  controller read data for this port
- bus_err  input  2  0 NO_ERROR, 1 IN_USE, 2 DUAL_WRITE, 3 DUAL_HOLD
- bus_ack  input  1  controller acknowledge

## Operation
- States: IDLE, HOLD, ADDR, DATA, RELEASE, BACKOFF.
- IDLE: when cmd_valid is high, latch the command, clear retry_cnt, go to HOLD.
- HOLD: assert bus_hold. If bus_ack and bus_err==0, go to ADDR. Otherwise go to BACKOFF.
- ADDR: drive bus_ad = {0, addr}, bus_enable=1, bus_rw=write. If bus_err==0, go to DATA. Otherwise go to BACKOFF. DUAL_WRITE is only possible here.
- DATA:
  - Write: drive bus_ad = wdata.
  - Read: capture bus_rdata into rsp_rdata at the end of the cycle.
  - Always go to RELEASE.
- RELEASE: pulse bus_release, drop bus_hold, pulse rsp_valid with rsp_err=0, return to IDLE.
- BACKOFF: drop all bus outputs.
  - If retry_cnt==MAX_RETRY: pulse rsp_valid with rsp_err = the error that caused entry, go to IDLE.
  - Otherwise: load a counter with (BACKOFF_BASE << retry_cnt) + PORT_ID, count down to 0, increment retry_cnt, go to HOLD.
- The retry counter is 4 bits and saturates at MAX_RETRY. The backoff counter is 8 bits, and the shift result saturates at 255.
- The latched command is stable for the whole transaction. Changes on cmd_* while busy are ignored.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: cmd_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0.
  - Bus: bus_ad=0; bus_rw=0; bus_enable=0; bus_hold=0; bus_release=0.
- Reset mid-transaction drops all bus outputs immediately. No rsp_valid is produced, and the command is lost.
- Uncontended transaction: accept in cycle 0, HOLD in 1, ADDR in 2, DATA in 3, RELEASE with rsp_valid in 4. Latency is 4 cycles; the next command is accepted in cycle 5.
- bus_err and bus_ack are sampled combinationally at the end of the HOLD and ADDR cycles.
- rsp_valid is high for exactly one cycle per accepted command.
- rsp_rdata is updated only for a successful read.

## Configuration
- CSM_INIT_BACKOFF_EN defined: retry/backoff behaviour as described above.
- CSM_INIT_BACKOFF_EN undefined:
  - The BACKOFF state and its counters are removed.
  - Any nonzero bus_err in HOLD or ADDR goes directly to a response cycle (rsp_valid=1, rsp_err=code) and then to IDLE.
  - MAX_RETRY, BACKOFF_BASE and PORT_ID are ignored.

## Test plan
- Write 0x5A to addr 3, no contention:
  - bus_hold rises in cycle 1.
  - Cycle 2: bus_enable=1, bus_rw=1, bus_ad=0x03.
  - Cycle 3: bus_ad=0x5A.
  - Cycle 4: rsp_valid=1, rsp_err=0.
- Read addr 3 with bus_rdata=0x5A in DATA: rsp_rdata=0x5A and rsp_valid in cycle 4, bus_rw=0 throughout.
- bus_err=IN_USE in HOLD for 2 attempts then clear (PORT_ID=1, BACKOFF_BASE=2): backoff lengths 3 then 5, success on the third attempt, rsp_err=0.
- bus_err=DUAL_HOLD held permanently, MAX_RETRY=3: exactly 4 HOLD attempts, then rsp_valid with rsp_err=3 and all bus outputs 0.
- bus_err=DUAL_WRITE in ADDR once: no DATA cycle and no bus_release on that attempt; the retry succeeds.
- reset_n low during DATA: all bus outputs 0 asynchronously, no rsp_valid, cmd_ready=1 after reset.
